// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle.
// Signed or unsigned, with start/annul/ready handshake to the execute stage.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BYZERO,
        S_ON,
        S_END
    } state_t;

    state_t state_q, state_n;

    logic [CW-1:0]      cnt_q, cnt_n;
    logic [WIDTH-1:0]   p_q, p_n;
    logic [WIDTH-1:0]   d_q, d_n;
    logic [WIDTH-1:0]   q_q, q_n;
    logic [WIDTH-1:0]   v_q, v_n;
    logic               qneg_q, qneg_n;
    logic               rneg_q, rneg_n;
    logic [2*WIDTH-1:0] result_n;
    logic               ready_n;

    logic [WIDTH:0]     t;
    logic [WIDTH:0]     diff;
    logic               neg1;
    logic               neg2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            p_q      <= '0;
            d_q      <= '0;
            q_q      <= '0;
            v_q      <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            p_q      <= p_n;
            d_q      <= d_n;
            q_q      <= q_n;
            v_q      <= v_n;
            qneg_q   <= qneg_n;
            rneg_q   <= rneg_n;
            result_o <= result_n;
            ready_o  <= ready_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        p_n      = p_q;
        d_n      = d_q;
        q_n      = q_q;
        v_n      = v_q;
        qneg_n   = qneg_q;
        rneg_n   = rneg_q;
        result_n = result_o;
        ready_n  = ready_o;

        t    = {p_q, d_q[WIDTH-1]};
        diff = t - {1'b0, v_q};
        neg1 = signed_div_i & opdata1_i[WIDTH-1];
        neg2 = signed_div_i & opdata2_i[WIDTH-1];

        unique case (state_q)
            S_IDLE: begin
                if (!annul_i && start_i) begin
                    if (opdata2_i == '0) begin
                        state_n = S_BYZERO;
                    end else begin
                        state_n = S_ON;
                        d_n     = neg1 ? -opdata1_i : opdata1_i;
                        v_n     = neg2 ? -opdata2_i : opdata2_i;
                        qneg_n  = neg1 ^ neg2;
                        rneg_n  = neg1;
                        p_n     = '0;
                        q_n     = '0;
                        cnt_n   = '0;
                    end
                end
            end
            S_BYZERO: begin
                result_n = '0;
                ready_n  = 1'b0;
                state_n  = annul_i ? S_IDLE : S_END;
            end
            S_ON: begin
                if (annul_i) begin
                    state_n  = S_IDLE;
                    result_n = '0;
                    ready_n  = 1'b0;
                end else if (cnt_q == LAST) begin
                    state_n  = S_END;
                    result_n = {rneg_q ? -p_q : p_q,
                                qneg_q ? -q_q : q_q};
                    ready_n  = 1'b1;
                end else begin
                    // A clear borrow bit means the divisor fit this step.
                    if (!diff[WIDTH]) begin
                        p_n = diff[WIDTH-1:0];
                        q_n = {q_q[WIDTH-2:0], 1'b1};
                    end else begin
                        p_n = t[WIDTH-1:0];
                        q_n = {q_q[WIDTH-2:0], 1'b0};
                    end
                    d_n   = d_q << 1;
                    cnt_n = cnt_q + 1'b1;
                end
            end
            S_END: begin
                if (!annul_i && start_i) begin
                    // Divide-by-zero arrives here with ready still low.
                    ready_n = 1'b1;
                end else begin
                    state_n  = S_IDLE;
                    result_n = '0;
                    ready_n  = 1'b0;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed corner cases plus a
// randomized signed/unsigned sweep against a plain-arithmetic model.
module tb_div_iter;

    logic        clk;
    logic        rst;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int errors = 0;
    int checks = 0;

    div_iter #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (opdata1),
        .opdata2_i    (opdata2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {remainder, quotient} from truncating integer division.
    function automatic logic [63:0] model(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic s);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int exp_lat(input logic [31:0] b);
        return (b == 32'd0) ? 2 : 33;
    endfunction

    // Full handshake: raise start, wait for ready, hold one cycle, drop.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           input logic s,
                           output logic [63:0] res, output int lat,
                           output logic [63:0] held, output logic held_rdy,
                           output logic [63:0] after, output logic after_rdy);
        opdata1    = a;
        opdata2    = b;
        signed_div = s;
        start      = 1'b1;
        lat        = -1;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (n == 0) begin
                opdata1    = $urandom;
                opdata2    = $urandom;
                signed_div = ~s;
            end
            if (ready) begin
                lat = n;
                break;
            end
        end
        res = result;
        tick();
        held     = result;
        held_rdy = ready;
        start    = 1'b0;
        tick();
        after     = result;
        after_rdy = ready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b want 0", ready);
        end
        checks++;
        if (result !== 64'd0) begin
            errors++;
            $display("FAIL reset_result: got %h want 0", result);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [63:0] res, held, after;
        logic        hr, ar;
        int          lat;
        run_div(32'd100, 32'd7, 1'b0, res, lat, held, hr, after, ar);
        checks++;
        if (lat !== 33) begin
            errors++;
            $display("FAIL u100_7_latency: got %0d want 33", lat);
        end
        checks++;
        if (res !== 64'h00000002_0000000E) begin
            errors++;
            $display("FAIL u100_7_result: got %h want 000000020000000e", res);
        end
        checks++;
        if (held !== 64'h00000002_0000000E || hr !== 1'b1) begin
            errors++;
            $display("FAIL u100_7_hold: got %h/%b want 000000020000000e/1",
                     held, hr);
        end
        checks++;
        if (after !== 64'd0 || ar !== 1'b0) begin
            errors++;
            $display("FAIL u100_7_release: got %h/%b want 0/0", after, ar);
        end
    endtask

    task automatic test_signed();
        logic [31:0] av [2] = '{32'hFFFFFFF9, 32'hFFFFFFF9};
        logic        sv [2] = '{1'b1, 1'b0};
        logic [63:0] ev [2] = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000001_7FFFFFFC};
        logic [63:0] res, held, after;
        logic        hr, ar;
        int          lat;
        for (int i = 0; i < 2; i++) begin
            run_div(av[i], 32'd2, sv[i], res, lat, held, hr, after, ar);
            checks++;
            if (res !== ev[i] || lat !== 33) begin
                errors++;
                $display("FAIL sign_case%0d: got %h lat %0d want %h lat 33",
                         i, res, lat, ev[i]);
            end
        end
    endtask

    task automatic test_byzero();
        logic [63:0] res, held, after;
        logic        hr, ar;
        int          lat;
        for (int s = 0; s < 2; s++) begin
            run_div(32'd5, 32'd0, s[0], res, lat, held, hr, after, ar);
            checks++;
            if (lat !== 2) begin
                errors++;
                $display("FAIL byzero%0d_latency: got %0d want 2", s, lat);
            end
            checks++;
            if (res !== 64'd0 || held !== 64'd0 || hr !== 1'b1) begin
                errors++;
                $display("FAIL byzero%0d_result: got %h/%h/%b want 0/0/1",
                         s, res, held, hr);
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] bv [2] = '{32'hFFFFFFFF, 32'h00000001};
        logic [63:0] res, held, after;
        logic        hr, ar;
        int          lat;
        for (int i = 0; i < 2; i++) begin
            run_div(32'h80000000, bv[i], 1'b1, res, lat, held, hr, after, ar);
            checks++;
            if (res !== 64'h00000000_80000000 || lat !== 33) begin
                errors++;
                $display("FAIL minneg_case%0d: got %h lat %0d want 0000000080000000 lat 33",
                         i, res, lat);
            end
        end
    endtask

    task automatic test_abort(input logic use_rst);
        logic [63:0] res, held, after;
        logic        hr, ar;
        logic        seen;
        int          lat;
        opdata1    = 32'd1000;
        opdata2    = 32'd3;
        signed_div = 1'b0;
        start      = 1'b1;
        for (int n = 0; n < 10; n++) tick();
        if (use_rst) rst = 1'b1;
        else annul = 1'b1;
        start = 1'b0;
        tick();
        rst   = 1'b0;
        annul = 1'b0;
        checks++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            errors++;
            $display("FAIL abort%0d_clear: got %h/%b want 0/0",
                     use_rst, result, ready);
        end
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (ready) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL abort%0d_noready: got ready %b want 0", use_rst, seen);
        end
        run_div(32'd9, 32'd3, 1'b0, res, lat, held, hr, after, ar);
        checks++;
        if (res !== 64'h00000000_00000003 || lat !== 33) begin
            errors++;
            $display("FAIL abort%0d_retry: got %h lat %0d want 3 lat 33",
                     use_rst, res, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] res, held, after;
        logic        hr, ar;
        int          lat;
        run_div(32'd12345, 32'd67, 1'b0, res, lat, held, hr, after, ar);
        checks++;
        if (after !== 64'd0 || ar !== 1'b0) begin
            errors++;
            $display("FAIL b2b_release: got %h/%b want 0/0", after, ar);
        end
        run_div(32'hFFFF0000, 32'h00000123, 1'b1, res, lat, held, hr, after, ar);
        checks++;
        if (res !== model(32'hFFFF0000, 32'h00000123, 1'b1) || lat !== 33) begin
            errors++;
            $display("FAIL b2b_second: got %h lat %0d want %h lat 33",
                     res, lat, model(32'hFFFF0000, 32'h00000123, 1'b1));
        end
    endtask

    task automatic test_random();
        logic [63:0] res, held, after, exp;
        logic        hr, ar, s;
        logic [31:0] a, b;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: a = 32'h80000000;
                3: b = b >> $urandom_range(1, 31);
                4: a = a >> $urandom_range(1, 31);
                default: ;
            endcase
            exp = model(a, b, s);
            run_div(a, b, s, res, lat, held, hr, after, ar);
            checks++;
            if (res !== exp || lat !== exp_lat(b) || held !== exp) begin
                errors++;
                $display("FAIL rand%0d %h/%h s%b: got %h lat %0d want %h lat %0d",
                         i, a, b, s, res, lat, exp, exp_lat(b));
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        signed_div = 1'b0;
        opdata1    = '0;
        opdata2    = '0;
        start      = 1'b0;
        annul      = 1'b0;
        test_reset();
        test_basic();
        test_signed();
        test_byzero();
        test_overflow();
        test_abort(1'b0);
        test_abort(1'b1);
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_iter.md
# div_iter

Iterative radix-2 restoring divider with a parametrised operand width, selectable signed or unsigned mode, and a start/annul/ready handshake. It is the multi-cycle divide unit beside the execute stage. The execute stage raises `start_i` and stalls until `ready_o`, then writes quotient to LO and remainder to HI. Fixed latency, one quotient bit per cycle; annul cancels an in-flight divide when the pipeline flushes.

## Interface
- `WIDTH`, default 32: operand width in bits; legal values ≥ 2.
- `clk` input 1: rising-edge clock.
- `rst` input 1: reset, synchronous, active-high.
- `signed_div_i` input 1: 1 = two's-complement divide, 0 = unsigned; sampled only on start acceptance.
- `opdata1_i` input WIDTH: dividend; sampled only on start acceptance.
- `opdata2_i` input WIDTH: divisor; sampled only on start acceptance.
- `start_i` input 1: request; held high by the caller until it has seen `ready_o`.
- `annul_i` input 1: cancel current operation.
- `result_o` output 2*WIDTH: {remainder, quotient}, so remainder is in [2*WIDTH-1:WIDTH] and quotient in [WIDTH-1:0]; registered.
- `ready_o` output 1: result valid; registered.

## Operation
- State register: IDLE, BYZERO, ON, END.
- Counter `cnt`: clog2(WIDTH+1) bits.
- Working registers: partial remainder P (WIDTH bits), dividend shift register D (WIDTH bits), quotient Q (WIDTH bits), latched divisor magnitude V, latched sign flags.
- Reset (`rst`=1 at an edge, priority over everything):
  - state becomes IDLE and `cnt` becomes 0;
  - `ready_o` becomes 0 and `result_o` becomes 0.
- IDLE:
  - `annul_i`=1: stay IDLE; annul takes priority over start.
  - else `start_i`=1 and divisor = 0: go to BYZERO.
  - else `start_i`=1: go to ON and latch the operands:
    - D ← |opdata1_i| and V ← |opdata2_i|; magnitude is taken only when `signed_div_i`=1 and the operand MSB is 1, otherwise the raw value is used;
    - quotient-negative flag ← `signed_div_i` & (op1 MSB ^ op2 MSB);
    - remainder-negative flag ← `signed_div_i` & op1 MSB;
    - P ← 0, Q ← 0, `cnt` ← 0.
- BYZERO: next edge goes to END with `result_o` = 0 (divide by zero returns quotient 0, remainder 0; no exception).
- ON, `cnt` < WIDTH, one iteration per edge:
  - T = {P, D[WIDTH-1]}, WIDTH+1 bits;
  - diff = T − {1'b0, V};
  - if diff ≥ 0: P ← diff[WIDTH-1:0] and shift a 1 into Q's LSB; else P ← T[WIDTH-1:0] and shift in 0;
  - D ← D << 1; `cnt` ← `cnt` + 1.
- ON, `cnt` = WIDTH: go to END.
  - quotient field ← quotient-negative ? −Q : Q;
  - remainder field ← remainder-negative ? −P : P;
  - `ready_o` ← 1.
- END:
  - `start_i`=1 and `annul_i`=0: hold; `result_o` and `ready_o` stay stable.
  - `start_i`=0: go to IDLE; `ready_o` ← 0 and `result_o` ← 0.
- Annul in BYZERO, ON or END: next edge goes to IDLE with `ready_o`=0 and `result_o`=0. No result is produced for the annulled request.
- A new request is accepted only from IDLE. Leaving END costs one IDLE cycle before the next start is sampled.
- Arithmetic rules:
  - all negation is two's-complement modulo 2^WIDTH;
  - most-negative / −1 in signed mode yields quotient 0x80…0 and remainder 0, with no overflow flag;
  - the remainder sign follows the dividend and |remainder| < |divisor|;
  - operand changes after acceptance have no effect.

## Timing
- Edge 0 is the first edge with IDLE & `start_i` & !`annul_i`.
- Nonzero divisor:
  - edges 1…WIDTH iterate;
  - edge WIDTH+1 enters END;
  - `ready_o` is high from edge WIDTH+1, i.e. WIDTH+1 edges after acceptance (33 edges for WIDTH=32).
- Zero divisor: `ready_o` is high from edge 2.
- `ready_o` falls on the first edge at which `start_i`=0 is sampled in END.
- The outputs are driven only from registers; there is no combinational path from inputs to outputs.
- Reset or annul mid-operation takes effect at the next edge; the partially computed state is discarded.

## Test plan
- Unsigned 100 / 7, WIDTH=32 -> `ready_o` rises at edge 33; `result_o` = 0x00000002_0000000E; with `start_i` held, values stay stable.
- Signed −7 / 2 (0xFFFFFFF9, 0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also unsigned 0xFFFFFFF9 / 2 -> quotient 0x7FFFFFFC, remainder 1.
- 5 / 0, either mode -> `ready_o` at edge 2; `result_o` = 0.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0. Also 0x80000000 / 1 -> quotient 0x80000000, remainder 0.
- `annul_i` pulse at edge 10 of a divide -> IDLE at edge 11 and `ready_o` never rises. A fresh 9 / 3 then completes normally with result 0x00000000_00000003. Repeat the sequence with `rst` instead of annul.
- Back-to-back divides:
  - deassert `start_i` one cycle after `ready_o` -> `ready_o`=0 and `result_o`=0 the next cycle;
  - re-raise `start_i` with new operands -> second result is correct with the same latency;
  - a random signed/unsigned sweep matches a reference model.
